// File: rtl/axis_lrelu_stream_tx_pkg.sv
// axis_lrelu_stream_tx_pkg: shared tuser indices, config beat counts and framing FSM encoding
package axis_lrelu_stream_tx_pkg;
  localparam int TUSER_WIDTH = 8;
  localparam int I_IS_1X1 = 5;
  localparam int CONFIG_BEATS_3X3 = 21;
  localparam int CONFIG_BEATS_1X1 = 13;
  localparam int CNT_WIDTH = $clog2(CONFIG_BEATS_3X3);
  typedef enum logic [1:0] {CFG_FIRST = 2'd0, CFG_REST = 2'd1, DATA = 2'd2} state_t;
  // The first config beat is already consumed when the counter loads, and count 0 marks the final beat
  function automatic logic [CNT_WIDTH-1:0] cfg_load(input logic is_1x1);
    return CNT_WIDTH'((is_1x1 ? CONFIG_BEATS_1X1 : CONFIG_BEATS_3X3) - 2);
  endfunction
endpackage

// File: rtl/axis_skid_slice.sv
// axis_skid_slice: 2-entry register slice with registered ready and full throughput
module axis_skid_slice #(
  parameter int WIDTH = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             push, pop;
  assign in_ready = ~skid_valid;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      skid_valid <= 1'b0;
      skid_data <= '0;
    end else if (skid_valid) begin
      if (pop) begin
        out_data <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (push && out_valid && !pop) begin
      skid_data <= in_data;
      skid_valid <= 1'b1;
    end else if (push) begin
      out_data <= in_data;
      out_valid <= 1'b1;
    end else if (pop)
      out_valid <= 1'b0;
endmodule

// File: rtl/axis_lrelu_stream_tx.sv
// axis_lrelu_stream_tx: frames config beats then conv data beats into the LRelu engine stream
module axis_lrelu_stream_tx
  import axis_lrelu_stream_tx_pkg::*;
#(
  parameter  int WORD_WIDTH_IN = 32,
  parameter  int UNITS = 8,
  parameter  int GROUPS = 2,
  parameter  int COPIES = 2,
  parameter  int MEMBERS = 2,
  localparam int W = MEMBERS * COPIES * GROUPS * UNITS * WORD_WIDTH_IN
)(
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_cfg_tvalid,
  output logic                   s_cfg_tready,
  input  logic [W-1:0]           s_cfg_tdata,
  input  logic [TUSER_WIDTH-1:0] s_cfg_tuser,
  input  logic                   s_cfg_tlast,
  input  logic                   s_dat_tvalid,
  output logic                   s_dat_tready,
  input  logic [W-1:0]           s_dat_tdata,
  input  logic [TUSER_WIDTH-1:0] s_dat_tuser,
  input  logic                   s_dat_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [W-1:0]           m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   iter_done,
  output logic                   cfg_err
);
  localparam int SW = W + TUSER_WIDTH + 1;
  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                   is_1x1, is_1x1_nxt;
  logic                   in_ready, slice_ready, cfg_hs, dat_hs, cfg_final, cur_1x1;
  logic [TUSER_WIDTH-1:0] cfg_user;
  logic [SW-1:0]          in_data, out_data;
  assign slice_ready = in_ready & ~areset;
  assign s_cfg_tready = slice_ready & (state != DATA);
  assign s_dat_tready = slice_ready & (state == DATA);
  assign cfg_hs = s_cfg_tvalid & s_cfg_tready;
  assign dat_hs = s_dat_tvalid & s_dat_tready;
  assign cfg_final = (state == CFG_REST) && (cnt == '0);
  // The live flag is used on the first beat so every config beat carries the same tuser
  assign cur_1x1 = (state == CFG_FIRST) ? s_cfg_tuser[I_IS_1X1] : is_1x1;
  assign cfg_user = TUSER_WIDTH'(cur_1x1) << I_IS_1X1;
  assign in_data = (state == DATA) ? {s_dat_tlast, s_dat_tuser, s_dat_tdata} : {1'b0, cfg_user, s_cfg_tdata};
  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = out_data;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    is_1x1_nxt = is_1x1;
    if (cfg_hs && state == CFG_FIRST) begin
      is_1x1_nxt = s_cfg_tuser[I_IS_1X1];
      cnt_nxt = cfg_load(s_cfg_tuser[I_IS_1X1]);
      state_nxt = CFG_REST;
    end else if (cfg_hs) begin
      cnt_nxt = cfg_final ? cnt : cnt - 1'b1;
      state_nxt = cfg_final ? DATA : CFG_REST;
    end else if (dat_hs && s_dat_tlast)
      state_nxt = CFG_FIRST;
  end
  always_ff @(posedge aclk)
    if (areset) begin
      state <= CFG_FIRST;
      cnt <= '0;
      is_1x1 <= 1'b0;
      cfg_err <= 1'b0;
      iter_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      is_1x1 <= is_1x1_nxt;
      cfg_err <= cfg_err | (cfg_hs & (s_cfg_tlast != cfg_final));
      iter_done <= dat_hs & s_dat_tlast;
    end
  axis_skid_slice #(.WIDTH(SW)) u_slice (
    .clk(aclk),
    .rst(areset),
    .in_valid(cfg_hs | dat_hs),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data(out_data)
  );
endmodule

// File: tb/tb_axis_lrelu_stream_tx.sv
// tb_axis_lrelu_stream_tx: random iterations checked against a per-iteration expected output sequence
module tb_axis_lrelu_stream_tx;
  import axis_lrelu_stream_tx_pkg::*;
  localparam int W = 2 * 2 * 2 * 8 * 32;
  typedef struct {
    logic [W-1:0] d;
    logic [7:0]   u;
    logic         l;
  } beat_t;
  logic         aclk = 0, areset = 1;
  logic         s_cfg_tvalid = 0, s_cfg_tready, s_cfg_tlast = 0;
  logic [W-1:0] s_cfg_tdata = '0;
  logic [7:0]   s_cfg_tuser = '0;
  logic         s_dat_tvalid = 0, s_dat_tready, s_dat_tlast = 0;
  logic [W-1:0] s_dat_tdata = '0;
  logic [7:0]   s_dat_tuser = '0;
  logic         m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
  logic [W-1:0] m_axis_tdata;
  logic [7:0]   m_axis_tuser;
  logic         iter_done, cfg_err;
  int n_checks = 0, n_fail = 0;
  beat_t cfgq[$], datq[$], expq[$];
  int duty = 100, cfg_sent = 0, iter_cfg_n = 0, exp_done = 0, done_cnt = 0, cyc = 0;
  int phase_n = 0, phase_first = 0, phase_last = 0, phase_b5 = 0;
  bit in_iter = 0, exp_err = 0, rnd_b5 = 0;

  axis_lrelu_stream_tx dut (
    .aclk(aclk), .areset(areset),
    .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready), .s_cfg_tdata(s_cfg_tdata),
    .s_cfg_tuser(s_cfg_tuser), .s_cfg_tlast(s_cfg_tlast),
    .s_dat_tvalid(s_dat_tvalid), .s_dat_tready(s_dat_tready), .s_dat_tdata(s_dat_tdata),
    .s_dat_tuser(s_dat_tuser), .s_dat_tlast(s_dat_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .iter_done(iter_done), .cfg_err(cfg_err)
  );

  initial forever #5 aclk = ~aclk;
  initial forever begin
    @(posedge aclk);
    #1;
    m_axis_tready = ($urandom_range(99) < duty);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge aclk) if (!areset) begin
    beat_t e;
    cyc++;
    chk("cfg_err", cfg_err, exp_err);
    if (iter_done) done_cnt++;
    if (in_iter && s_dat_tready) chk("dat_ready_during_cfg", cfg_sent, iter_cfg_n);
    if (in_iter && s_cfg_tready) chk("cfg_ready_after_cfg", cfg_sent < iter_cfg_n, 1);
    if (m_axis_tvalid && m_axis_tready) begin
      if (expq.size() == 0) chk("unexpected_beat", m_axis_tvalid, 0);
      else begin
        e = expq.pop_front();
        n_checks++;
        if (m_axis_tdata !== e.d) begin
          n_fail++;
          $display("FAIL tdata: got %0h expected %0h (low word)", m_axis_tdata[31:0], e.d[31:0]);
        end
        chk("tuser", m_axis_tuser, e.u);
        chk("tlast", m_axis_tlast, e.l);
        if (phase_n == 0) phase_first = cyc;
        phase_last = cyc;
        phase_n++;
        if (m_axis_tuser[5]) phase_b5++;
      end
    end
  end

  task automatic drive(input bit c, input int gap);
    beat_t b;
    bit hs;
    int wd, n;
    n = c ? cfgq.size() : datq.size();
    for (int i = 0; i < n; i++) begin
      b = c ? cfgq[i] : datq[i];
      while ($urandom_range(99) < gap) begin
        if (c) s_cfg_tvalid = 0; else s_dat_tvalid = 0;
        @(posedge aclk);
        #1;
      end
      if (c) begin
        s_cfg_tvalid = 1; s_cfg_tdata = b.d; s_cfg_tuser = b.u; s_cfg_tlast = b.l;
      end else begin
        s_dat_tvalid = 1; s_dat_tdata = b.d; s_dat_tuser = b.u; s_dat_tlast = b.l;
      end
      wd = 0;
      hs = 0;
      while (!hs && wd < 3000) begin
        @(negedge aclk);
        hs = c ? (s_cfg_tvalid && s_cfg_tready) : (s_dat_tvalid && s_dat_tready);
        @(posedge aclk);
        #1;
        wd++;
      end
      if (!hs) chk("handshake_timeout", hs, 1);
      else if (c) begin
        cfg_sent++;
        if (b.l != (i == n - 1)) exp_err = 1;
      end else if (b.l) exp_done++;
    end
    if (c) s_cfg_tvalid = 0; else s_dat_tvalid = 0;
  endtask

  // Model: an iteration emits its N config beats (tuser = only the 1x1 flag, no tlast) then its data beats verbatim
  task automatic run_iter(input bit is1x1, input int ndata, input int err_beat, input int gap, input bit with_last);
    beat_t b, e;
    int n;
    n = is1x1 ? 13 : 21;
    cfgq.delete();
    datq.delete();
    for (int i = 0; i < n; i++) begin
      b.d = rand_word();
      b.u = 8'($urandom);
      b.u[5] = (i == 0) ? is1x1 : 1'($urandom);
      b.l = (i == n - 1) || (err_beat != 0 && i == err_beat - 1);
      cfgq.push_back(b);
      e.d = b.d;
      e.u = is1x1 ? 8'h20 : 8'h00;
      e.l = 0;
      expq.push_back(e);
    end
    for (int j = 0; j < ndata; j++) begin
      b.d = rand_word();
      b.u = 8'($urandom);
      if (!rnd_b5) b.u[5] = 0;
      b.l = with_last && (j == ndata - 1);
      datq.push_back(b);
      expq.push_back(b);
    end
    iter_cfg_n = n;
    cfg_sent = 0;
    in_iter = 1;
    fork
      drive(1, gap);
      drive(0, gap);
    join
    in_iter = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (expq.size() != 0 && k < 5000) begin
      @(posedge aclk);
      #1;
      k++;
    end
    chk("drain", expq.size(), 0);
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata_zero", m_axis_tdata == '0, 1);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_iter_done", iter_done, 0);
    chk("rst_cfg_ready", s_cfg_tready, 0);
    chk("rst_dat_ready", s_dat_tready, 0);
    @(posedge aclk);
    #1;
    areset = 0;
    // 3x3 then 1x1, no gaps: 61 + 23 beats with no bubble
    run_iter(0, 40, 0, 0, 1);
    run_iter(1, 10, 0, 0, 1);
    drain();
    chk("phaseA_beats", phase_n, 84);
    chk("phaseA_no_bubble", phase_last - phase_first, 83);
    chk("phaseA_is1x1_beats", phase_b5, 13);
    chk("phaseA_iter_done", done_cnt, 2);
    chk("phaseA_cfg_err", cfg_err, 0);
    rnd_b5 = 1;
    duty = 30;
    run_iter(0, 25, 0, 30, 1);
    run_iter(1, 12, 0, 30, 1);
    drain();
    chk("phaseB_iter_done", done_cnt, 4);
    duty = 70;
    run_iter(0, 8, 10, 0, 1);
    drain();
    chk("early_tlast_cfg_err", cfg_err, 1);
    chk("phaseC_iter_done", done_cnt, 5);
    duty = 60;
    repeat (4) run_iter(1'($urandom), $urandom_range(1, 20), 0, 20, 1);
    drain();
    duty = 100;
    run_iter(0, 4, 0, 0, 0);
    areset = 1;
    expq.delete();
    exp_err = 0;
    s_dat_tvalid = 1;
    s_dat_tdata = rand_word();
    @(negedge aclk);
    chk("reset_cfg_ready", s_cfg_tready, 0);
    chk("reset_dat_ready", s_dat_tready, 0);
    @(posedge aclk);
    #1;
    areset = 0;
    @(negedge aclk);
    chk("post_reset_m_tvalid", m_axis_tvalid, 0);
    chk("post_reset_dat_ready", s_dat_tready, 0);
    @(posedge aclk);
    #1;
    run_iter(0, 6, 0, 0, 1);
    run_iter(1, 5, 0, 10, 1);
    drain();
    chk("iter_done_total", done_cnt, exp_done);
    chk("final_cfg_err", cfg_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_lrelu_stream_tx.md
Name: axis_lrelu_stream_tx

Overview:
- Transmitter that builds the per-iteration stream consumed by the LRelu engine's slave port: N config beats, then conv data beats up to a tlast, repeated.
- Merges a config stream from the weights/config DMA with the conv-core output stream.
- Guarantees engine framing: tuser[I_IS_1X1] is stable across config beats, no data leaks during config, and tlast appears only on the final data beat.
- Sits between the conv core and the LRelu engine.

Parameters:
- WORD_WIDTH_IN, 32, conv output word width.
- UNITS, 8; GROUPS, 2; COPIES, 2; MEMBERS, 2: array dimensions. Beat width W = MEMBERS*COPIES*GROUPS*UNITS*WORD_WIDTH_IN.
- CONFIG_BEATS_3X3, 21, total config beats for a 3x3 iteration.
- CONFIG_BEATS_1X1, 13, total config beats for a 1x1 iteration.
- I_IS_1X1, 5, tuser bit index of the 1x1 flag.
- TUSER_WIDTH, 8, tuser width, equal to TUSER_WIDTH_LRELU_IN.

Ports:
- aclk, in, 1: clock.
- areset, in, 1: reset, synchronous, active-high.
- s_cfg_tvalid, in, 1.
- s_cfg_tready, out, 1.
- s_cfg_tdata, in, W: config beat.
- s_cfg_tuser, in, TUSER_WIDTH: [I_IS_1X1] is valid on the first config beat.
- s_cfg_tlast, in, 1: marks the last config beat of the iteration.
- s_dat_tvalid, in, 1.
- s_dat_tready, out, 1.
- s_dat_tdata, in, W: conv output.
- s_dat_tuser, in, TUSER_WIDTH.
- s_dat_tlast, in, 1: end of iteration.
- m_axis_tvalid, out, 1.
- m_axis_tready, in, 1.
- m_axis_tdata, out, W.
- m_axis_tuser, out, TUSER_WIDTH.
- m_axis_tlast, out, 1.
- iter_done, out, 1: one-cycle pulse when the data tlast is accepted into the output slice.
- cfg_err, out, 1: sticky; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high):
  - State is CFG_FIRST; counter = 0; latched is_1x1 = 0.
  - Slice empty: m_axis_tvalid = 0, tdata/tuser/tlast = 0.
  - cfg_err = 0, iter_done = 0.
  - s_cfg_tready = 0 and s_dat_tready = 0 during reset.
  - Reset mid-iteration discards all partial state; the next beat expected is a first config beat.
- Output slice: 2-entry skid register. One-cycle latency from input handshake to m_axis_tvalid. Full throughput, one beat per clock. slice_ready = slice not full.
- FSM:
  - CFG_FIRST:
    - s_cfg_tready = slice_ready; s_dat_tready = 0.
    - On cfg handshake: latch is_1x1 = s_cfg_tuser[I_IS_1X1]; load count = (is_1x1 ? CONFIG_BEATS_1X1 : CONFIG_BEATS_3X3) - 2; go to CFG_REST.
  - CFG_REST:
    - s_cfg_tready = slice_ready; s_dat_tready = 0.
    - On each handshake: count decrements. The handshake at count == 0 is the last config beat and moves the FSM to DATA.
  - DATA:
    - s_cfg_tready = 0; s_dat_tready = slice_ready.
    - Data passes through.
    - On data handshake with s_dat_tlast: pulse iter_done and go to CFG_FIRST.
- Output muxing:
  - Config beats: m_axis_tdata = s_cfg_tdata; m_axis_tlast = 0; m_axis_tuser = 0 except bit I_IS_1X1 = latched is_1x1 (on the first beat, the live s_cfg_tuser bit). The value is held identical on every config beat.
  - Data beats: tdata, tuser and tlast are forwarded unchanged.
- Config framing check:
  - s_cfg_tlast on a non-final config beat sets cfg_err.
  - Missing s_cfg_tlast on the final beat sets cfg_err.
  - Framing is always driven by the count, never by s_cfg_tlast.
- Boundary conditions:
  - Zero-length data phase is impossible; DATA always waits for at least one beat.
  - A tlast data beat followed by a config beat on the next cycle gives back-to-back output with no bubble.
  - m_axis_tready low with the slice full: both s_*_tready go low, and all state and counters hold.
  - Counter width = clog2(CONFIG_BEATS_3X3). The counter never wraps, because the decrement is gated by state.
  - Simultaneous s_cfg_tvalid and s_dat_tvalid: only the port allowed by the current state is ready.

Decomposition:
- Shared package holds:
  - tuser index constants (I_IS_* ), TUSER_WIDTH.
  - CONFIG_BEATS_3X3 / CONFIG_BEATS_1X1.
  - The FSM state encoding (CFG_FIRST = 0, CFG_REST = 1, DATA = 2), also used by the engine-side checker.
- One sub-module: axis_skid_slice (parameterised width W+TUSER_WIDTH+1, 2-entry, registered valid/ready).

Test Plan:
- 3x3 iteration, m_axis_tready = 1:
  - Stimulus: 21 cfg beats with tuser[5] = 0, tlast on beat 21; then 40 data beats with tlast on beat 40.
  - Required: 61 consecutive m beats; tuser[5] = 0 on all cfg beats; m_axis_tlast only on beat 61; iter_done pulses once; cfg_err = 0.
- 1x1 iteration:
  - Stimulus: 13 cfg beats, tuser[5] = 1 on the first beat only.
  - Required: all 13 m beats carry tuser[5] = 1; the beat after them is the first data beat; s_dat_tready = 0 throughout beats 1-13.
- Backpressure:
  - Stimulus: random m_axis_tready at 30% duty across two back-to-back iterations (3x3, then 1x1).
  - Required: output sequence identical to the no-backpressure case; no beat lost or duplicated.
- Early cfg tlast:
  - Stimulus: s_cfg_tlast asserted on cfg beat 10 of 21.
  - Required: cfg_err = 1 from the next cycle and stays set; exactly 21 cfg beats are still forwarded before data.
- Mid-iteration reset:
  - Stimulus: areset asserted for 1 cycle during data beat 5.
  - Required: m_axis_tvalid = 0 on the next cycle; s_dat_tready = 0; the next accepted beat comes from s_cfg, with count reloaded.
- Interleaved valids:
  - Stimulus: s_dat_tvalid held high during the cfg phase.
  - Required: no data beat is accepted until the final cfg handshake; the first data beat appears on the clock after it.
